// File: rtl/wb_ram_arbiter_if.sv
// Bus bundle between the two Wishbone masters, the arbiter and the ACK-less RAM.
// The slave modport is the arbiter's view; master is the view of the surrounding core/RAM.
interface wb_ram_arbiter_if;
    logic        M0_CYC_I;
    logic        M0_STB_I;
    logic        M0_WE_I;
    logic [31:0] M0_ADR_I;
    logic [31:0] M0_DAT_I;
    logic [31:0] M0_DAT_O;
    logic        M0_ACK_O;

    logic        M1_CYC_I;
    logic        M1_STB_I;
    logic        M1_WE_I;
    logic [31:0] M1_ADR_I;
    logic [31:0] M1_DAT_I;
    logic [31:0] M1_DAT_O;
    logic        M1_ACK_O;

    logic        S_STB_O;
    logic        S_WE_O;
    logic [31:0] S_ADR_O;
    logic [31:0] S_DAT_O;
    logic [31:0] S_DAT_I;

    logic [1:0]  GNT_O;

    modport slave (
        input  M0_CYC_I, M0_STB_I, M0_WE_I, M0_ADR_I, M0_DAT_I,
        output M0_DAT_O, M0_ACK_O,
        input  M1_CYC_I, M1_STB_I, M1_WE_I, M1_ADR_I, M1_DAT_I,
        output M1_DAT_O, M1_ACK_O,
        output S_STB_O, S_WE_O, S_ADR_O, S_DAT_O,
        input  S_DAT_I,
        output GNT_O
    );

    modport master (
        output M0_CYC_I, M0_STB_I, M0_WE_I, M0_ADR_I, M0_DAT_I,
        input  M0_DAT_O, M0_ACK_O,
        output M1_CYC_I, M1_STB_I, M1_WE_I, M1_ADR_I, M1_DAT_I,
        input  M1_DAT_O, M1_ACK_O,
        input  S_STB_O, S_WE_O, S_ADR_O, S_DAT_O,
        output S_DAT_I,
        input  GNT_O
    );
endinterface

// File: rtl/wb_ram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of a zero-wait, ACK-less RAM.
// Generates per-master ACKs; CYC locks the bus, optional burst limit restores fairness.
module wb_ram_arbiter #(
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned CNT_W     = 4
) (
    input  logic               CLK_I,
    input  logic               RST_I,
    wb_ram_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BURST);
    localparam bit               LIMIT_EN = (MAX_BURST != 0);

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       gnt_q, gnt_d;

    logic        ack0, ack1, stb, we;
    logic [31:0] adr, dat;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ack0    = 1'b0;
        ack1    = 1'b0;
        stb     = 1'b0;
        we      = 1'b0;
        adr     = '0;
        dat     = '0;

        unique case (state_q)
            IDLE: begin
                // last_q = 1 means M1 was served last, so M0 wins a tie
                if (bus.M0_CYC_I && (!bus.M1_CYC_I || last_q)) begin
                    state_d = GRANT0;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                end else if (bus.M1_CYC_I) begin
                    state_d = GRANT1;
                    last_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            GRANT0: begin
                we  = bus.M0_WE_I;
                adr = bus.M0_ADR_I;
                dat = bus.M0_DAT_I;
                if (!bus.M0_CYC_I) begin
                    state_d = IDLE;
                end else if (LIMIT_EN && cnt_q == MAX_CNT && bus.M1_CYC_I) begin
                    state_d = IDLE;
                end else if (bus.M0_STB_I) begin
                    ack0 = 1'b1;
                    stb  = 1'b1;
                    if (cnt_q != MAX_CNT) cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GRANT1: begin
                we  = bus.M1_WE_I;
                adr = bus.M1_ADR_I;
                dat = bus.M1_DAT_I;
                if (!bus.M1_CYC_I) begin
                    state_d = IDLE;
                end else if (LIMIT_EN && cnt_q == MAX_CNT && bus.M0_CYC_I) begin
                    state_d = IDLE;
                end else if (bus.M1_STB_I) begin
                    ack1 = 1'b1;
                    stb  = 1'b1;
                    if (cnt_q != MAX_CNT) cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        gnt_d = {state_d == GRANT1, state_d == GRANT0};
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    // Reset gates the strobes combinationally so an in-flight write never commits
    assign bus.M0_ACK_O = ack0 & ~RST_I;
    assign bus.M1_ACK_O = ack1 & ~RST_I;
    assign bus.S_STB_O  = stb & ~RST_I;
    assign bus.S_WE_O   = we & ~RST_I;
    assign bus.S_ADR_O  = adr;
    assign bus.S_DAT_O  = dat;
    assign bus.M0_DAT_O = bus.S_DAT_I;
    assign bus.M1_DAT_O = bus.S_DAT_I;
    assign bus.GNT_O    = gnt_q;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter: stimulus queues expected transfers, a monitor
// pops and compares them on every ACK; a small behavioural RAM sits on the slave side.
module tb_wb_ram_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_ram_arbiter_if bus();

    wb_ram_arbiter #(.MAX_BURST(8), .CNT_W(4)) dut (
        .CLK_I (clk),
        .RST_I (rst),
        .bus   (bus)
    );

    // Behavioural RAM: combinational read, write on the clock edge
    logic [31:0] mem [0:63];
    bit          mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4]   <= 32'hDEADBEEF;
            mem[5]   <= 32'hCAFEF00D;
            mem[14]  <= 32'h55AA55AA;
            mem_init <= 1'b1;
        end else if (bus.S_STB_O && bus.S_WE_O) begin
            mem[bus.S_ADR_O[7:2]] <= bus.S_DAT_O;
        end
    end

    assign bus.S_DAT_I = mem[bus.S_ADR_O[7:2]];

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   checks = 0;
    int   errors = 0;
    int   ack0_n = 0;
    int   ack1_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // Monitor: every ACK consumes one queued expectation for that master
    always @(negedge clk) begin
        if (bus.M0_ACK_O || bus.M1_ACK_O)
            chk1("dual_ack", bus.M0_ACK_O & bus.M1_ACK_O, 1'b0);
        if (bus.M0_ACK_O) begin
            ack0_n++;
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL m0_unexpected_ack: got ack at adr 0x%08h expected none", bus.S_ADR_O);
            end else begin
                e0 = q0.pop_front();
                chk("m0_adr", bus.S_ADR_O, e0.adr);
                chk1("m0_we", bus.S_WE_O, e0.we);
                if (e0.we) chk("m0_wdat", bus.S_DAT_O, e0.dat);
                else       chk("m0_rdat", bus.M0_DAT_O, e0.dat);
            end
        end
        if (bus.M1_ACK_O) begin
            ack1_n++;
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL m1_unexpected_ack: got ack at adr 0x%08h expected none", bus.S_ADR_O);
            end else begin
                e1 = q1.pop_front();
                chk("m1_adr", bus.S_ADR_O, e1.adr);
                chk1("m1_we", bus.S_WE_O, e1.we);
                if (e1.we) chk("m1_wdat", bus.S_DAT_O, e1.dat);
                else       chk("m1_rdat", bus.M1_DAT_O, e1.dat);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat);
        if (m == 0) begin
            bus.M0_CYC_I = cyc; bus.M0_STB_I = stb; bus.M0_WE_I = we;
            bus.M0_ADR_I = adr; bus.M0_DAT_I = dat;
        end else begin
            bus.M1_CYC_I = cyc; bus.M1_STB_I = stb; bus.M1_WE_I = we;
            bus.M1_ADR_I = adr; bus.M1_DAT_I = dat;
        end
    endtask

    task automatic push(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat);
        exp_t e;
        e.we = we; e.adr = adr; e.dat = dat;
        if (m == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic idle_in();
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    int b0, b1;

    initial begin
        // Reset state and single M0 read
        idle_in();
        rst = 1'b1;
        tick(); tick();
        at_neg();
        chk("rst_gnt", {30'h0, bus.GNT_O}, 32'h0);
        chk1("rst_ack0", bus.M0_ACK_O, 1'b0);
        chk1("rst_stb", bus.S_STB_O, 1'b0);
        tick();
        rst = 1'b0;
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        push(0, 1'b0, 32'h10, 32'hDEADBEEF);
        at_neg();
        chk("t1_idle_gnt", {30'h0, bus.GNT_O}, 32'h0);
        chk1("t1_idle_stb", bus.S_STB_O, 1'b0);
        chk1("t1_idle_ack", bus.M0_ACK_O, 1'b0);
        tick(); at_neg();
        chk("t1_gnt", {30'h0, bus.GNT_O}, 32'h1);
        chk1("t1_m0_ack", bus.M0_ACK_O, 1'b1);
        chk1("t1_m1_ack", bus.M1_ACK_O, 1'b0);
        tick();
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        at_neg();
        chk1("t1_drop_ack", bus.M0_ACK_O, 1'b0);
        tick(); at_neg();
        chk("t1_back_idle", {30'h0, bus.GNT_O}, 32'h0);

        // M1 write then locked read-back
        tick();
        set_m(1, 1'b1, 1'b1, 1'b1, 32'h20, 32'h12345678);
        push(1, 1'b1, 32'h20, 32'h12345678);
        at_neg();
        tick(); at_neg();
        chk("t2_gnt", {30'h0, bus.GNT_O}, 32'h2);
        chk1("t2_wr_ack", bus.M1_ACK_O, 1'b1);
        chk1("t2_wr_we", bus.S_WE_O, 1'b1);
        tick();
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        push(1, 1'b0, 32'h20, 32'h12345678);
        at_neg();
        chk1("t2_rd_ack", bus.M1_ACK_O, 1'b1);
        tick();
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        at_neg();
        tick(); at_neg();

        // Tie out of reset, handover through IDLE, next tie back to M0
        do_reset();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h14, 32'h0);
        push(0, 1'b0, 32'h10, 32'hDEADBEEF);
        push(0, 1'b0, 32'h10, 32'hDEADBEEF);
        push(1, 1'b0, 32'h14, 32'hCAFEF00D);
        at_neg();
        tick(); at_neg();
        chk("t3_first_m0", {30'h0, bus.GNT_O}, 32'h1);
        chk1("t3_m1_held", bus.M1_ACK_O, 1'b0);
        tick(); at_neg();
        tick();
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        at_neg();
        chk1("t3_drop_noack", bus.M0_ACK_O | bus.M1_ACK_O, 1'b0);
        tick(); at_neg();
        chk("t3_idle_gap", {30'h0, bus.GNT_O}, 32'h0);
        tick(); at_neg();
        chk("t3_then_m1", {30'h0, bus.GNT_O}, 32'h2);
        chk1("t3_m1_ack", bus.M1_ACK_O, 1'b1);
        tick();
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        at_neg();
        tick();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h14, 32'h0);
        push(0, 1'b0, 32'h10, 32'hDEADBEEF);
        at_neg();
        tick(); at_neg();
        chk("t3_tie2_m0", {30'h0, bus.GNT_O}, 32'h1);
        tick();
        idle_in();
        at_neg();
        tick(); at_neg();
        tick(); at_neg();

        // Burst limit: 8 M0 ACKs, one suppressed cycle, IDLE, then M1
        do_reset();
        b0 = ack0_n; b1 = ack1_n;
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h14, 32'h0);
        for (int k = 0; k < 13; k++) push(0, 1'b0, 32'h10, 32'hDEADBEEF);
        for (int k = 0; k < 2; k++)  push(1, 1'b0, 32'h14, 32'hCAFEF00D);
        at_neg();
        for (int k = 1; k <= 8; k++) begin tick(); at_neg(); end
        chk("t4_m0_burst", ack0_n - b0, 32'd8);
        chk("t4_m1_wait", ack1_n - b1, 32'd0);
        tick(); at_neg();
        chk1("t4_supp_ack", bus.M0_ACK_O, 1'b0);
        chk1("t4_supp_stb", bus.S_STB_O, 1'b0);
        chk("t4_supp_gnt", {30'h0, bus.GNT_O}, 32'h1);
        tick(); at_neg();
        chk("t4_idle", {30'h0, bus.GNT_O}, 32'h0);
        tick(); at_neg();
        chk("t4_m1_gnt", {30'h0, bus.GNT_O}, 32'h2);
        tick(); at_neg();
        chk("t4_m1_served", ack1_n - b1, 32'd2);
        tick();
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        at_neg();
        for (int k = 14; k <= 19; k++) begin tick(); at_neg(); end
        tick();
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        at_neg();
        tick(); at_neg();
        chk("t4_m0_total", ack0_n - b0, 32'd13);

        // M1 idle: no limit, 20 back-to-back M0 ACKs
        b0 = ack0_n;
        tick();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        for (int k = 0; k < 20; k++) push(0, 1'b0, 32'h10, 32'hDEADBEEF);
        at_neg();
        for (int k = 1; k <= 20; k++) begin
            tick(); at_neg();
            chk1("t4b_ack", bus.M0_ACK_O, 1'b1);
        end
        tick();
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        at_neg();
        tick(); at_neg();
        chk("t4b_m0_total", ack0_n - b0, 32'd20);

        // Reset in the middle of an M1 write burst
        do_reset();
        set_m(1, 1'b1, 1'b1, 1'b1, 32'h30, 32'hA1A1A1A1);
        push(1, 1'b1, 32'h30, 32'hA1A1A1A1);
        at_neg();
        tick(); at_neg();
        tick();
        set_m(1, 1'b1, 1'b1, 1'b1, 32'h34, 32'hA2A2A2A2);
        push(1, 1'b1, 32'h34, 32'hA2A2A2A2);
        at_neg();
        tick();
        set_m(1, 1'b1, 1'b1, 1'b1, 32'h38, 32'hA3A3A3A3);
        rst = 1'b1;
        at_neg();
        chk1("t5_rst_ack", bus.M1_ACK_O, 1'b0);
        chk1("t5_rst_stb", bus.S_STB_O, 1'b0);
        chk1("t5_rst_we", bus.S_WE_O, 1'b0);
        tick();
        rst = 1'b0;
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h14, 32'h0);
        push(0, 1'b0, 32'h10, 32'hDEADBEEF);
        at_neg();
        chk("t5_gnt_after", {30'h0, bus.GNT_O}, 32'h0);
        chk("t5_no_write", mem[14], 32'h55AA55AA);
        chk("t5_wr0", mem[12], 32'hA1A1A1A1);
        chk("t5_wr1", mem[13], 32'hA2A2A2A2);
        tick(); at_neg();
        chk("t5_tie_m0", {30'h0, bus.GNT_O}, 32'h1);
        chk1("t5_m0_ack", bus.M0_ACK_O, 1'b1);
        tick();
        idle_in();
        at_neg();
        tick(); at_neg();

        // STB without CYC is ignored
        tick();
        set_m(0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        for (int k = 0; k < 3; k++) begin
            at_neg();
            chk("t6_gnt", {30'h0, bus.GNT_O}, 32'h0);
            chk1("t6_ack", bus.M0_ACK_O, 1'b0);
            chk1("t6_stb", bus.S_STB_O, 1'b0);
            tick();
        end
        idle_in();
        tick(); at_neg();

        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
